// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: requests one word, holds it for
// decode, and absorbs branch/jump redirects including those racing a transfer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] instr_p1, instr_p1_nxt;
  logic [31:0] instr_pc_nxt;
  logic [31:0] count_nxt;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    addr_nxt     = imem_addr;
    instr_p1_nxt = instr_p1;
    instr_pc_nxt = instr_pc;
    count_nxt    = fetch_count;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        if (redirect_valid) begin
          pc_nxt   = redir_pc;
          addr_nxt = redir_pc;
        end else begin
          addr_nxt = pc;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_nxt   = redir_pc;
            addr_nxt = redir_pc;
          end else begin
            state_nxt    = HOLD;
            instr_p1_nxt = imem_rdata;
            instr_pc_nxt = imem_addr;
            pc_nxt       = imem_addr + 32'd4;
          end
        end else if (redirect_valid) begin
          // request address must stay put until the stale transfer completes
          state_nxt = DRAIN;
          pc_nxt    = redir_pc;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_nxt = FETCH;
          if (redirect_valid) begin
            pc_nxt   = redir_pc;
            addr_nxt = redir_pc;
          end else begin
            addr_nxt = pc;
          end
        end else if (redirect_valid) begin
          pc_nxt = redir_pc;
        end
      end
      HOLD: begin
        // redirect squashes the held instruction even if decode takes it
        if (redirect_valid) begin
          state_nxt = FETCH;
          pc_nxt    = redir_pc;
          addr_nxt  = redir_pc;
        end else if (instr_ready) begin
          state_nxt = FETCH;
          addr_nxt  = pc;
          count_nxt = fetch_count + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- held instruction / address registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= PC_INIT;
      imem_addr   <= PC_INIT;
      instr_p1    <= NOP_INSTR;
      instr_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      pc          <= pc_nxt;
      imem_addr   <= addr_nxt;
      instr_p1    <= instr_p1_nxt;
      instr_pc    <= instr_pc_nxt;
      fetch_count <= count_nxt;
    end
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign instr_valid = (state == HOLD);
  assign instr       = instr_valid ? instr_p1 : NOP_INSTR;
  assign opcode      = instr[6:0];
  assign func3       = instr[14:12];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch unit.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  // transaction-level model: started / request outstanding / squash pending / holding
  bit          m_started, m_req, m_squash, m_have;
  logic [31:0] m_pc, m_addr, m_instr, m_ipc, m_count;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_count(fetch_count)
  );

  task automatic model_reset();
    m_started = 0; m_req = 0; m_squash = 0; m_have = 0;
    m_pc = RESET_PC; m_addr = RESET_PC; m_instr = NOP; m_ipc = 32'h0; m_count = 32'h0;
  endtask

  // advance one clock; the model consumes the inputs present at the edge
  task automatic tick();
    logic [31:0] ra;
    @(posedge clk);
    ra = redirect_pc & ~32'h3;
    if (rst_n) begin
      if (!m_started) begin
        if (redirect_valid) m_pc = ra;
        m_addr = m_pc; m_req = 1; m_squash = 0; m_started = 1;
      end else if (m_have) begin
        if (redirect_valid) begin
          m_have = 0; m_pc = ra; m_addr = ra; m_req = 1;
        end else if (instr_ready) begin
          m_have = 0; m_count = m_count + 1; m_addr = m_pc; m_req = 1;
        end
      end else if (m_req) begin
        if (imem_ack) begin
          if (m_squash || redirect_valid) begin
            if (redirect_valid) m_pc = ra;
            m_addr = m_pc; m_squash = 0;
          end else begin
            m_have = 1; m_req = 0; m_instr = imem_rdata; m_ipc = m_addr; m_pc = m_addr + 4;
          end
        end else if (redirect_valid) begin
          m_pc = ra; m_squash = 1;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0; imem_rdata = 0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({imem_req, instr_valid, imem_addr, instr, instr_pc, fetch_count} !== {1'b0, 1'b0, RESET_PC, NOP, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL reset_values act req=%0b vld=%0b addr=%h instr=%h pc=%h cnt=%0d exp 0 0 %h %h 0 0",
               imem_req, instr_valid, imem_addr, instr, instr_pc, fetch_count, RESET_PC, NOP);
    end
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle act req=%0b vld=%0b exp 0 0", imem_req, instr_valid);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    imem_ack = 1; instr_ready = 1; imem_rdata = 32'h0050_0093;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'(4 * k)}) begin
        bad++;
        $display("FAIL seq_req%0d act req=%0b vld=%0b addr=%h exp 1 0 %h", k, imem_req, instr_valid, imem_addr, 32'(4 * k));
      end
      tick();
      total++;
      if ({instr_valid, imem_req, instr, instr_pc, opcode, func3} !== {1'b1, 1'b0, 32'h0050_0093, 32'(4 * k), 7'b0010011, 3'b000}) begin
        bad++;
        $display("FAIL seq_hold%0d act vld=%0b req=%0b instr=%h pc=%h op=%b f3=%b exp 1 0 00500093 %h 0010011 000",
                 k, instr_valid, imem_req, instr, instr_pc, opcode, func3, 32'(4 * k));
      end
    end
    tick();
    total++;
    if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'hC, 32'd3}) begin
      bad++;
      $display("FAIL seq_count act req=%0b addr=%h cnt=%0d exp 1 0000000c 3", imem_req, imem_addr, fetch_count);
    end
    imem_ack = 0; instr_ready = 0;
  endtask

  task automatic test_wait_ack(output logic [31:0] word);
    apply_reset();
    redirect_valid = 1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h10}) begin
        bad++;
        $display("FAIL wait_req%0d act req=%0b vld=%0b addr=%h exp 1 0 00000010", i, imem_req, instr_valid, imem_addr);
      end
    end
    word = $urandom;
    imem_ack = 1; imem_rdata = word;
    tick();
    imem_ack = 0;
    total++;
    if ({instr_valid, imem_req, instr_pc, instr} !== {1'b1, 1'b0, 32'h10, word}) begin
      bad++;
      $display("FAIL wait_hold act vld=%0b req=%0b pc=%h instr=%h exp 1 0 00000010 %h", instr_valid, imem_req, instr_pc, instr, word);
    end
  endtask

  task automatic test_stall(input logic [31:0] word);
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      tick();
      total++;
      if ({instr_valid, imem_req, instr, instr_pc, fetch_count} !== {1'b1, 1'b0, word, 32'h10, 32'd0}) begin
        bad++;
        $display("FAIL stall%0d act vld=%0b req=%0b instr=%h pc=%h cnt=%0d exp 1 0 %h 00000010 0",
                 i, instr_valid, imem_req, instr, instr_pc, fetch_count, word);
      end
    end
    imem_ack = 0; instr_ready = 1;
    tick();
    instr_ready = 0;
    total++;
    if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'h14, 32'd1}) begin
      bad++;
      $display("FAIL stall_release act req=%0b addr=%h cnt=%0d exp 1 00000014 1", imem_req, imem_addr, fetch_count);
    end
  endtask

  task automatic test_drain_redirect();
    apply_reset();
    redirect_valid = 1; redirect_pc = 32'h8;
    tick();
    redirect_pc = 32'h203;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      total++;
      if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h8}) begin
        bad++;
        $display("FAIL drain%0d act req=%0b vld=%0b addr=%h exp 1 0 00000008", i, imem_req, instr_valid, imem_addr);
      end
    end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h200}) begin
      bad++;
      $display("FAIL drain_refetch act req=%0b vld=%0b addr=%h exp 1 0 00000200", imem_req, instr_valid, imem_addr);
    end
    imem_rdata = 32'h00A0_0113;
    tick();
    imem_ack = 0;
    total++;
    if ({instr_valid, instr_pc, instr, func3} !== {1'b1, 32'h200, 32'h00A0_0113, 3'b000}) begin
      bad++;
      $display("FAIL drain_hold act vld=%0b pc=%h instr=%h f3=%b exp 1 00000200 00a00113 000", instr_valid, instr_pc, instr, func3);
    end
  endtask

  task automatic test_redirect_hold();
    instr_ready = 1; redirect_valid = 1; redirect_pc = 32'h1002;
    tick();
    redirect_valid = 0;
    total++;
    if ({imem_req, instr_valid, imem_addr, fetch_count} !== {1'b1, 1'b0, 32'h1000, 32'd0}) begin
      bad++;
      $display("FAIL squash act req=%0b vld=%0b addr=%h cnt=%0d exp 1 0 00001000 0", imem_req, instr_valid, imem_addr, fetch_count);
    end
    imem_ack = 1; imem_rdata = 32'h0000_7033;
    tick();
    imem_ack = 0;
    total++;
    if ({instr_valid, instr_pc, func3} !== {1'b1, 32'h1000, 3'b111}) begin
      bad++;
      $display("FAIL squash_hold act vld=%0b pc=%h f3=%b exp 1 00001000 111", instr_valid, instr_pc, func3);
    end
    tick();
    instr_ready = 0;
    total++;
    if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'h1004, 32'd1}) begin
      bad++;
      $display("FAIL squash_next act req=%0b addr=%h cnt=%0d exp 1 00001004 1", imem_req, imem_addr, fetch_count);
    end
  endtask

  task automatic test_wrap_and_reset();
    apply_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0; imem_ack = 1; imem_rdata = $urandom;
    tick();
    imem_ack = 0;
    total++;
    if ({instr_valid, instr_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
      bad++;
      $display("FAIL wrap_hold act vld=%0b pc=%h exp 1 fffffffc", instr_valid, instr_pc);
    end
    instr_ready = 1;
    tick();
    instr_ready = 0;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL wrap_addr act req=%0b addr=%h exp 1 00000000", imem_req, imem_addr);
    end
    redirect_valid = 1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 0;
    tick();
    total++;
    if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'h0, 32'd1}) begin
      bad++;
      $display("FAIL wrap_drain act req=%0b addr=%h cnt=%0d exp 1 00000000 1", imem_req, imem_addr, fetch_count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({imem_req, instr_valid, imem_addr, instr, instr_pc, fetch_count} !== {1'b0, 1'b0, RESET_PC, NOP, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL async_reset act req=%0b vld=%0b addr=%h instr=%h pc=%h cnt=%0d exp 0 0 %h %h 0 0",
               imem_req, instr_valid, imem_addr, instr, instr_pc, fetch_count, RESET_PC, NOP);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      bad++;
      $display("FAIL restart act req=%0b addr=%h exp 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    logic [107:0] got, exp;
    logic [31:0]  e_instr;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      imem_ack       = ($urandom_range(0, 2) == 0);
      imem_rdata     = $urandom;
      instr_ready    = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = $urandom;
      tick();
      e_instr = m_have ? m_instr : NOP;
      got = {imem_req, instr_valid, imem_addr, instr, opcode, func3, fetch_count};
      exp = {m_req, m_have, m_addr, e_instr, e_instr[6:0], e_instr[14:12], m_count};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rand_cycle%0d act=%h exp=%h", c, got, exp);
      end
      if (m_have) begin
        total++;
        if (instr_pc !== m_ipc) begin
          bad++;
          $display("FAIL rand_pc%0d act=%h exp=%h", c, instr_pc, m_ipc);
        end
      end
    end
    imem_ack = 0; instr_ready = 0; redirect_valid = 0;
  endtask

  initial begin
    logic [31:0] word;
    model_reset();
    test_reset();
    test_sequential();
    test_wait_ack(word);
    test_stall(word);
    test_drain_redirect();
    test_redirect_hold();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
